// File: rtl/alu_issue_wb_stage_if.sv
// alu_issue_wb_stage_if: instruction issue and writeback handshake channels
// issue: in_valid/in_instr (to stage), in_ready (from stage)
// writeback: wb_valid/wb_rd/wb_data (from stage), wb_ready (to stage)
interface alu_issue_wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  modport master (output in_valid, in_instr, wb_ready, input in_ready, wb_valid, wb_rd, wb_data);
  modport slave  (input in_valid, in_instr, wb_ready, output in_ready, wb_valid, wb_rd, wb_data);
endinterface

// File: rtl/alu_issue_wb_stage.sv
// alu_issue_wb_stage: operand issue, EX/W registers and regfile commit around an external alu
// ports: clk, rst_n (async low); s = issue/writeback channels; alu_rs1/alu_rs2/alu_I to alu, alu_o back;
// dbg_we/dbg_addr/dbg_wdata/dbg_rdata debug regfile port; illegal_cnt (saturating), retired_cnt (wrapping)
module alu_issue_wb_stage #(
  parameter int RET_W = 16,
  parameter int ILL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_wb_stage_if.slave s,
  output logic [31:0]        alu_rs1,
  output logic [31:0]        alu_rs2,
  output logic [31:0]        alu_I,
  input  logic [31:0]        alu_o,
  input  logic               dbg_we,
  input  logic [4:0]         dbg_addr,
  input  logic [31:0]        dbg_wdata,
  output logic [31:0]        dbg_rdata,
  output logic [ILL_W-1:0]   illegal_cnt,
  output logic [RET_W-1:0]   retired_cnt
);
  logic [31:0] rf [32];
  logic        ex_valid, w_free, ex_free, ex_move, accept, legal, ld;
  logic [4:0]  rs1, rs2, ex_rd;
  logic [31:0] op_a, op_b;
  assign rs1 = s.in_instr[19:15];
  assign rs2 = s.in_instr[24:20];
  assign ex_rd = alu_I[11:7];
  always_comb begin
    w_free = !s.wb_valid | s.wb_ready;
    ex_free = !ex_valid | w_free;
    ex_move = ex_valid & w_free;
    accept = s.in_valid & ex_free;
    legal = s.in_instr[6:0] == 7'b0110011 &&
            {s.in_instr[31:25], s.in_instr[14:12]} inside
            {10'b0000000000, 10'b0100000000, 10'b0000000001, 10'b0000000110, 10'b0000000111};
    ld = accept & legal;
    // an accept with EX occupied implies EX is retiring this edge, so bypass only needs ex_move
    op_a = rs1 == 5'd0 ? '0 : (ex_move && ex_rd == rs1) ? alu_o : rf[rs1];
    op_b = rs2 == 5'd0 ? '0 : (ex_move && ex_rd == rs2) ? alu_o : rf[rs2];
    dbg_rdata = dbg_addr == 5'd0 ? '0 : rf[dbg_addr];
  end
  assign s.in_ready = ex_free;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid <= 1'b0;
      alu_I <= '0;
      alu_rs1 <= '0;
      alu_rs2 <= '0;
    end else if (ex_free) begin
      ex_valid <= ld;
      alu_I <= ld ? s.in_instr : '0;
      alu_rs1 <= ld ? op_a : '0;
      alu_rs2 <= ld ? op_b : '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s.wb_valid <= 1'b0;
      s.wb_rd <= '0;
      s.wb_data <= '0;
    end else begin
      if (w_free) s.wb_valid <= ex_valid;
      if (ex_move) begin
        s.wb_rd <= ex_rd;
        s.wb_data <= alu_o;
      end
    end
  // pipeline write is placed last so it wins over a same-address debug write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (dbg_we && dbg_addr != 5'd0) rf[dbg_addr] <= dbg_wdata;
      if (ex_move && ex_rd != 5'd0) rf[ex_rd] <= alu_o;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      if (s.wb_valid && s.wb_ready) retired_cnt <= retired_cnt + RET_W'(1);
      if (accept && !legal && !(&illegal_cnt)) illegal_cnt <= illegal_cnt + ILL_W'(1);
    end
endmodule

// File: tb/tb_alu_issue_wb_stage.sv
// tb_alu_issue_wb_stage: directed and randomized checks against an in-order ISA-level model
module tb_alu_issue_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_rs1, alu_rs2, alu_I, alu_o;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic [31:0] dbg_rdata;
  logic [7:0]  illegal_cnt;
  logic [3:0]  retired_cnt;
  alu_issue_wb_stage_if bus();
  alu_issue_wb_stage #(.RET_W(4), .ILL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_I(alu_I), .alu_o(alu_o),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
    .illegal_cnt(illegal_cnt), .retired_cnt(retired_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic is_legal(logic [31:0] i);
    logic [9:0] f;
    f = {i[31:25], i[14:12]};
    return i[6:0] == 7'b0110011 &&
           (f == 10'h000 || f == 10'h100 || f == 10'h001 || f == 10'h006 || f == 10'h007);
  endfunction
  function automatic logic [31:0] ref_alu(logic [31:0] i, logic [31:0] a, logic [31:0] b);
    case ({i[31:25], i[14:12]})
      10'h000: return a + b;
      10'h100: return a - b;
      10'h001: return a << b[4:0];
      10'h006: return a | b;
      10'h007: return a & b;
      default: return 32'd0;
    endcase
  endfunction
  assign alu_o = ref_alu(alu_I, alu_rs1, alu_rs2);
  typedef struct { logic [4:0] rd; logic [31:0] d; } res_t;
  res_t        q[$];
  res_t        e;
  logic [31:0] mrf [32];
  logic [31:0] ma, mb, mr;
  int          ret_m = 0, ill_m = 0;
  int          vec = 0, errs = 0;
  always @(negedge clk) if (rst_n) begin
    if (bus.wb_valid && bus.wb_ready) begin
      vec++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL wb_unexpected got rd=%0d data=%h, none expected", bus.wb_rd, bus.wb_data);
      end else begin
        e = q.pop_front();
        if (bus.wb_rd !== e.rd || bus.wb_data !== e.d) begin
          errs++;
          $display("FAIL wb_result got rd=%0d data=%h exp rd=%0d data=%h", bus.wb_rd, bus.wb_data, e.rd, e.d);
        end
      end
      ret_m++;
    end
    if (bus.in_valid && bus.in_ready) begin
      if (is_legal(bus.in_instr)) begin
        ma = bus.in_instr[19:15] == 0 ? 32'd0 : mrf[bus.in_instr[19:15]];
        mb = bus.in_instr[24:20] == 0 ? 32'd0 : mrf[bus.in_instr[24:20]];
        mr = ref_alu(bus.in_instr, ma, mb);
        q.push_back('{bus.in_instr[11:7], mr});
        if (bus.in_instr[11:7] != 0) mrf[bus.in_instr[11:7]] = mr;
      end else if (ill_m < 255) ill_m++;
    end
    if (dbg_we && dbg_addr != 0) mrf[dbg_addr] = dbg_wdata;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] instr);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    if (n == 100) begin
      vec++; errs++;
      $display("FAIL issue_timeout in_ready=%b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic dbgw(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    step();
    dbg_we = 1'b0;
  endtask
  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.wb_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    issue(32'h003100b3);
    issue(32'h001080b3);
    #2 rst_n = 1'b0;
    #1;
    vec++; if (bus.wb_valid !== 1'b0) begin errs++; $display("FAIL rst_wb_valid got %b exp 0", bus.wb_valid); end
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    vec++; if ({alu_rs1, alu_rs2, alu_I} !== 96'd0) begin errs++; $display("FAIL rst_alu got %h %h %h exp 0", alu_rs1, alu_rs2, alu_I); end
    vec++; if ({bus.wb_rd, bus.wb_data} !== 37'd0) begin errs++; $display("FAIL rst_wb got rd=%0d data=%h exp 0", bus.wb_rd, bus.wb_data); end
    vec++; if (illegal_cnt !== 8'd0 || retired_cnt !== 4'd0) begin errs++; $display("FAIL rst_cnt got ill=%0d ret=%0d exp 0", illegal_cnt, retired_cnt); end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      vec++; if (dbg_rdata !== 32'd0) begin errs++; $display("FAIL rst_rf x%0d got %h exp 0", a, dbg_rdata); end
    end
    q.delete();
    for (int a = 0; a < 32; a++) mrf[a] = '0;
    ret_m = 0; ill_m = 0;
    step();
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    step();
  endtask
  task automatic test_add();
    dbgw(5'd2, 32'd10000);
    dbgw(5'd3, 32'd23456);
    issue(32'h003100b3);
    vec++; if (alu_rs1 !== 32'd10000 || alu_rs2 !== 32'd23456) begin errs++; $display("FAIL add_ops got %0d %0d exp 10000 23456", alu_rs1, alu_rs2); end
    vec++; if (alu_I !== 32'h003100b3) begin errs++; $display("FAIL add_I got %h exp 003100b3", alu_I); end
    step();
    vec++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd1 || bus.wb_data !== 32'd33456) begin errs++; $display("FAIL add_wb got v=%b rd=%0d data=%0d exp 1 1 33456", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    dbg_addr = 5'd1;
    #1;
    vec++; if (dbg_rdata !== 32'd33456) begin errs++; $display("FAIL add_x1 got %0d exp 33456", dbg_rdata); end
    step();
    vec++; if (bus.wb_valid !== 1'b0 || retired_cnt !== 4'd1) begin errs++; $display("FAIL add_drain got v=%b ret=%0d exp 0 1", bus.wb_valid, retired_cnt); end
  endtask
  task automatic test_bypass();
    issue(32'h003100b3);
    issue(32'h001080b3);
    vec++; if (alu_rs1 !== 32'd33456 || alu_rs2 !== 32'd33456) begin errs++; $display("FAIL byp_ops got %0d %0d exp 33456 33456", alu_rs1, alu_rs2); end
    vec++; if (bus.wb_data !== 32'd33456) begin errs++; $display("FAIL byp_wb1 got %0d exp 33456", bus.wb_data); end
    step();
    vec++; if (bus.wb_data !== 32'd66912) begin errs++; $display("FAIL byp_wb2 got %0d exp 66912", bus.wb_data); end
    dbg_addr = 5'd1;
    #1;
    vec++; if (dbg_rdata !== 32'd66912) begin errs++; $display("FAIL byp_x1 got %0d exp 66912", dbg_rdata); end
    step();
  endtask
  task automatic test_backpressure();
    bus.wb_ready = 1'b0;
    issue(32'h003100b3);
    issue(32'h003110b3);
    vec++; if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b1) begin errs++; $display("FAIL bp_full got rdy=%b v=%b exp 0 1", bus.in_ready, bus.wb_valid); end
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h403100b3;
    repeat (3) begin
      step();
      vec++; if (bus.in_ready !== 1'b0 || bus.wb_data !== 32'd33456) begin errs++; $display("FAIL bp_hold got rdy=%b data=%0d exp 0 33456", bus.in_ready, bus.wb_data); end
    end
    bus.wb_ready = 1'b1;
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bp_release got rdy=%b exp 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    vec++; if (q.size() != 0 || bus.wb_valid !== 1'b0) begin errs++; $display("FAIL bp_drain got pending=%0d v=%b exp 0 0", q.size(), bus.wb_valid); end
    vec++; if (retired_cnt !== 4'(ret_m)) begin errs++; $display("FAIL bp_ret got %0d exp %0d", retired_cnt, 4'(ret_m)); end
  endtask
  task automatic test_illegal();
    issue(32'h00312033);
    step();
    vec++; if (bus.wb_valid !== 1'b0 || alu_I !== 32'd0) begin errs++; $display("FAIL ill_drop got v=%b I=%h exp 0 0", bus.wb_valid, alu_I); end
    vec++; if (illegal_cnt !== 8'd1) begin errs++; $display("FAIL ill_cnt got %0d exp 1", illegal_cnt); end
    for (int a = 1; a < 4; a++) begin
      dbg_addr = 5'(a);
      #1;
      vec++; if (dbg_rdata !== mrf[a]) begin errs++; $display("FAIL ill_rf x%0d got %h exp %h", a, dbg_rdata, mrf[a]); end
    end
  endtask
  task automatic test_x0();
    dbgw(5'd1, 32'd5);
    issue(32'h00310033);
    issue(32'h00000233);
    vec++; if (alu_rs1 !== 32'd0 || alu_rs2 !== 32'd0) begin errs++; $display("FAIL x0_ops got %h %h exp 0 0", alu_rs1, alu_rs2); end
    vec++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'd33456) begin errs++; $display("FAIL x0_wb got v=%b rd=%0d data=%0d exp 1 0 33456", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    dbg_addr = 5'd0;
    #1;
    vec++; if (dbg_rdata !== 32'd0) begin errs++; $display("FAIL x0_rf got %h exp 0", dbg_rdata); end
    repeat (2) step();
  endtask
  task automatic test_random();
    logic [31:0] ins;
    int k, n;
    for (int a = 1; a < 32; a++) dbgw(5'(a), $urandom);
    for (int t = 0; t < 400; t++) begin
      bus.wb_ready = ($urandom % 4) != 0;
      #1;
      if ($urandom % 5 == 0) step();
      else begin
        k = $urandom % 6;
        ins = {7'd0, 5'($urandom), 5'($urandom), 3'd0, 5'($urandom), 7'b0110011};
        case (k)
          1: ins[31:25] = 7'b0100000;
          2: ins[14:12] = 3'b001;
          3: ins[14:12] = 3'b110;
          4: ins[14:12] = 3'b111;
          5: ins[14:12] = ($urandom % 2) ? 3'b010 : 3'b000;
          default: ;
        endcase
        if (k == 5 && ins[14:12] == 3'b000) ins[6:0] = 7'b0010011;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        n = 0;
        while (!bus.in_ready && n < 50) begin
          step();
          bus.wb_ready = ($urandom % 4) != 0;
          #1;
          n++;
        end
        if (n == 50) begin vec++; errs++; $display("FAIL rnd_timeout in_ready=%b exp 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
      end
    end
    bus.wb_ready = 1'b1;
    repeat (3) step();
    vec++; if (q.size() != 0) begin errs++; $display("FAIL rnd_drain got %0d pending exp 0", q.size()); end
    vec++; if (retired_cnt !== 4'(ret_m)) begin errs++; $display("FAIL rnd_ret got %0d exp %0d", retired_cnt, 4'(ret_m)); end
    vec++; if (illegal_cnt !== 8'(ill_m)) begin errs++; $display("FAIL rnd_ill got %0d exp %0d", illegal_cnt, ill_m); end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      vec++; if (dbg_rdata !== (a == 0 ? 32'd0 : mrf[a])) begin errs++; $display("FAIL rnd_rf x%0d got %h exp %h", a, dbg_rdata, mrf[a]); end
    end
  endtask
  task automatic test_saturate();
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00312033;
    repeat (300) step();
    bus.in_valid = 1'b0;
    step();
    vec++; if (illegal_cnt !== 8'hff) begin errs++; $display("FAIL sat_ill got %0d exp 255", illegal_cnt); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_backpressure();
    test_illegal();
    test_x0();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1);
  end
endmodule
